// File: rtl/ls161_pkg.sv
// ls161_pkg: counter width and terminal count shared by the ls161 model
package ls161_pkg;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
endpackage

// File: rtl/ttl_edge_det.sv
// ttl_edge_det: rising-edge detect of a TTL chip clock pin sampled on clk
module ttl_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic cp,
  output logic cp_rise
);
  logic cp_q;
  // history resets high so a pin held high across reset release is not an edge
  always_ff @(posedge clk or posedge reset)
    if (reset) cp_q <= 1'b1;
    else cp_q <= cp;
  assign cp_rise = cp & ~cp_q;
endmodule

// File: rtl/ls161.sv
// ls161: 74LS161/9316 synchronous 4-bit binary counter clocked from a sampled cp pin
module ls161
  import ls161_pkg::*;
#(
  parameter bit ASYNC_CLR = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cp,
  input  logic       clr_n,
  input  logic       load_n,
  input  logic       enp,
  input  logic       ent,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       rco
);
  logic cp_rise;
  logic [3:0] q_next;
  ttl_edge_det u_edge (
    .clk    (clk),
    .reset  (reset),
    .cp     (cp),
    .cp_rise(cp_rise)
  );
  // clear dominates load, load dominates counting
  always_comb begin
    q_next = q;
    if (ASYNC_CLR && !clr_n) q_next = '0;
    else if (cp_rise) q_next = !clr_n ? 4'h0 : !load_n ? d : (enp && ent) ? q + 4'd1 : q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else q <= q_next;
  assign rco = ent & (q == CNT_MAX);
endmodule

// File: tb/tb_ls161.sv
// tb_ls161: directed self-checking bench for the ls161 counter model
module tb_ls161;
  logic clk, reset;
  logic cp, clr_n, load_n, enp, ent;
  logic [3:0] d;
  logic [3:0] a_q, s_q, lo_q, hi_q;
  logic a_rco, s_rco, lo_rco, hi_rco;
  logic c_cp, c_enp, c_ent;
  int n_checks = 0;
  int n_fail = 0;

  ls161 #(.ASYNC_CLR(1'b1)) u_a (
    .clk(clk), .reset(reset), .cp(cp), .clr_n(clr_n), .load_n(load_n),
    .enp(enp), .ent(ent), .d(d), .q(a_q), .rco(a_rco)
  );
  ls161 #(.ASYNC_CLR(1'b0)) u_s (
    .clk(clk), .reset(reset), .cp(cp), .clr_n(clr_n), .load_n(load_n),
    .enp(enp), .ent(ent), .d(d), .q(s_q), .rco(s_rco)
  );
  ls161 u_lo (
    .clk(clk), .reset(reset), .cp(c_cp), .clr_n(1'b1), .load_n(1'b1),
    .enp(c_enp), .ent(c_ent), .d(4'h0), .q(lo_q), .rco(lo_rco)
  );
  ls161 u_hi (
    .clk(clk), .reset(reset), .cp(c_cp), .clr_n(1'b1), .load_n(1'b1),
    .enp(1'b1), .ent(lo_rco), .d(4'h0), .q(hi_q), .rco(hi_rco)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cp_pulse();
    cp = 1'b0;
    tick();
    cp = 1'b1;
    tick();
  endtask

  task automatic load(input logic [3:0] v);
    d = v;
    load_n = 1'b0;
    cp_pulse();
    load_n = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; cp = 1'b1; clr_n = 1'b1; load_n = 1'b1; enp = 1'b1; ent = 1'b1; d = 4'h0;
    c_cp = 1'b1; c_enp = 1'b1; c_ent = 1'b1;
    tick();
    tick();
    n_checks++;
    if (a_q !== 4'h0 || a_rco !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: q=%h rco=%b required q=0 rco=0", a_q, a_rco);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (a_q !== 4'h0 || s_q !== 4'h0 || a_rco !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_release cycle %0d: a_q=%h s_q=%h rco=%b required 0 0 0", i, a_q, s_q, a_rco);
      end
    end
  endtask

  task automatic test_count_wrap();
    logic [3:0] exp_q;
    for (int i = 1; i <= 17; i++) begin
      exp_q = 4'(i);
      cp = 1'b0;
      tick();
      cp = 1'b1;
      n_checks++;
      if (a_q !== 4'(i - 1)) begin
        n_fail++;
        $display("FAIL count_early step %0d: q=%h required %h", i, a_q, 4'(i - 1));
      end
      tick();
      n_checks++;
      if (a_q !== exp_q || s_q !== exp_q || a_rco !== (exp_q == 4'hF)) begin
        n_fail++;
        $display("FAIL count step %0d: a_q=%h s_q=%h rco=%b required q=%h rco=%b", i, a_q, s_q, a_rco, exp_q, exp_q == 4'hF);
      end
    end
  endtask

  task automatic test_load_priority();
    cp_pulse();
    cp_pulse();
    n_checks++;
    if (a_q !== 4'h3) begin
      n_fail++;
      $display("FAIL load_setup: q=%h required 3", a_q);
    end
    load(4'hA);
    n_checks++;
    if (a_q !== 4'hA || s_q !== 4'hA) begin
      n_fail++;
      $display("FAIL load_wins: a_q=%h s_q=%h required A", a_q, s_q);
    end
    cp_pulse();
    n_checks++;
    if (a_q !== 4'hB) begin
      n_fail++;
      $display("FAIL load_then_count: q=%h required B", a_q);
    end
  endtask

  task automatic test_clear_mode();
    load(4'h7);
    clr_n = 1'b0;
    n_checks++;
    if (a_q !== 4'h7 || s_q !== 4'h7) begin
      n_fail++;
      $display("FAIL clear_setup: a_q=%h s_q=%h required 7", a_q, s_q);
    end
    tick();
    n_checks++;
    if (a_q !== 4'h0 || s_q !== 4'h7) begin
      n_fail++;
      $display("FAIL clear_first_clk: a_q=%h s_q=%h required a=0 s=7", a_q, s_q);
    end
    tick();
    tick();
    cp = 1'b0;
    tick();
    n_checks++;
    if (a_q !== 4'h0 || s_q !== 4'h7) begin
      n_fail++;
      $display("FAIL clear_no_edge: a_q=%h s_q=%h required a=0 s=7", a_q, s_q);
    end
    cp = 1'b1;
    tick();
    n_checks++;
    if (s_q !== 4'h0) begin
      n_fail++;
      $display("FAIL clear_sync_edge: s_q=%h required 0", s_q);
    end
    d = 4'h5;
    load_n = 1'b0;
    cp_pulse();
    n_checks++;
    if (a_q !== 4'h0 || s_q !== 4'h0) begin
      n_fail++;
      $display("FAIL clear_over_load: a_q=%h s_q=%h required 0", a_q, s_q);
    end
    clr_n = 1'b1;
    load_n = 1'b1;
  endtask

  task automatic test_enable();
    load(4'hF);
    n_checks++;
    if (a_rco !== 1'b1) begin
      n_fail++;
      $display("FAIL rco_at_15: rco=%b required 1", a_rco);
    end
    ent = 1'b0;
    #1;
    n_checks++;
    if (a_rco !== 1'b0) begin
      n_fail++;
      $display("FAIL rco_ent_low: rco=%b required 0", a_rco);
    end
    cp_pulse();
    n_checks++;
    if (a_q !== 4'hF || a_rco !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_ent_low: q=%h rco=%b required F 0", a_q, a_rco);
    end
    enp = 1'b0;
    ent = 1'b1;
    cp_pulse();
    n_checks++;
    if (a_q !== 4'hF || a_rco !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_enp_low: q=%h rco=%b required F 1", a_q, a_rco);
    end
    enp = 1'b1;
    cp_pulse();
    n_checks++;
    if (a_q !== 4'h0 || a_rco !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_rco: q=%h rco=%b required 0 0", a_q, a_rco);
    end
  endtask

  task automatic test_cascade();
    n_checks++;
    if ({hi_q, lo_q} !== 8'h00) begin
      n_fail++;
      $display("FAIL cascade_start: count=%h required 00", {hi_q, lo_q});
    end
    for (int i = 1; i <= 47; i++) begin
      c_cp = 1'b0;
      tick();
      c_cp = 1'b1;
      tick();
      n_checks++;
      if ({hi_q, lo_q} !== 8'(i)) begin
        n_fail++;
        $display("FAIL cascade step %0d: count=%h required %h", i, {hi_q, lo_q}, 8'(i));
      end
    end
    c_ent = 1'b0;
    #1;
    n_checks++;
    if (lo_rco !== 1'b0) begin
      n_fail++;
      $display("FAIL cascade_rco_ent_low: rco=%b required 0", lo_rco);
    end
    c_cp = 1'b0;
    tick();
    c_cp = 1'b1;
    tick();
    n_checks++;
    if ({hi_q, lo_q} !== 8'h2F || lo_rco !== 1'b0) begin
      n_fail++;
      $display("FAIL cascade_hold: count=%h rco=%b required 2F 0", {hi_q, lo_q}, lo_rco);
    end
  endtask

  task automatic test_mid_reset();
    load(4'h9);
    n_checks++;
    if (a_q !== 4'h9) begin
      n_fail++;
      $display("FAIL mid_reset_setup: q=%h required 9", a_q);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (a_q !== 4'h0 || s_q !== 4'h0 || lo_q !== 4'h0) begin
      n_fail++;
      $display("FAIL mid_reset_async: a_q=%h s_q=%h lo_q=%h required 0", a_q, s_q, lo_q);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (a_q !== 4'h0) begin
        n_fail++;
        $display("FAIL mid_reset_cp_high cycle %0d: q=%h required 0", i, a_q);
      end
    end
    cp = 1'b0;
    tick();
    n_checks++;
    if (a_q !== 4'h0) begin
      n_fail++;
      $display("FAIL mid_reset_cp_low: q=%h required 0", a_q);
    end
    cp = 1'b1;
    tick();
    n_checks++;
    if (a_q !== 4'h1) begin
      n_fail++;
      $display("FAIL mid_reset_restart: q=%h required 1", a_q);
    end
  endtask

  initial begin
    test_reset();
    test_count_wrap();
    test_load_priority();
    test_clear_mode();
    test_enable();
    test_cascade();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
